// File: rtl/systolic_mm_engine.sv
// systolic_mm_engine: output-stationary DIM_R x DIM_C systolic matrix multiply.
// C = sum_k A[:,k] * B[k,:], with internal input skew and a start/busy/done FSM.
// Optional saturation of every accumulate when SYSTOLIC_SAT_EN is defined;
// otherwise accumulators wrap in two's complement. Port list is the same either way.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, k_len      job start (IDLE only) and reduction length
//   busy              high in every state except IDLE
//   in_valid/in_ready operand beat handshake (in_ready only in LOAD)
//   a_col, b_row      column k of A, row k of B
//   out_valid/ready   result row handshake
//   out_row_idx,c_row index and contents of the presented result row
//   done              one-cycle pulse after the last row is accepted
module systolic_mm_engine #(
    parameter int unsigned BITS_AB = 8,
    parameter int unsigned BITS_C  = 16,
    parameter int unsigned DIM_R   = 4,
    parameter int unsigned DIM_C   = 4,
    parameter int unsigned KW      = 8,
    localparam int unsigned RW     = (DIM_R > 1) ? $clog2(DIM_R) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [KW-1:0]                    k_len,
    output logic                             busy,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DIM_R-1:0][BITS_AB-1:0]    a_col,
    input  logic [DIM_C-1:0][BITS_AB-1:0]    b_row,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [RW-1:0]                    out_row_idx,
    output logic [DIM_C-1:0][BITS_C-1:0]     c_row,
    output logic                             done
);

    localparam int unsigned PW        = 2 * BITS_AB;
    localparam int unsigned FLUSH_LEN = DIM_R + DIM_C - 1;
    localparam int unsigned FW        = $clog2(FLUSH_LEN + 1);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    state_t              state, state_next;
    logic                clear, step, last_row;
    logic [KW-1:0]       k_rem;
    logic [FW-1:0]       flush_cnt;

    logic signed [BITS_AB-1:0] inj_a  [DIM_R];
    logic signed [BITS_AB-1:0] inj_b  [DIM_C];
    logic signed [BITS_AB-1:0] a_edge [DIM_R];
    logic signed [BITS_AB-1:0] b_edge [DIM_C];
    logic signed [BITS_AB-1:0] a_in   [DIM_R][DIM_C];
    logic signed [BITS_AB-1:0] b_in   [DIM_R][DIM_C];
    logic signed [BITS_AB-1:0] a_pe   [DIM_R][DIM_C];
    logic signed [BITS_AB-1:0] b_pe   [DIM_R][DIM_C];
    logic        [BITS_C-1:0]  prod   [DIM_R][DIM_C];
    logic [DIM_C-1:0][BITS_C-1:0] acc [DIM_R];

    // One accumulate step: wrap, or clamp on signed overflow.
    function automatic logic [BITS_C-1:0] acc_add(input logic [BITS_C-1:0] x,
                                                  input logic [BITS_C-1:0] y);
`ifdef SYSTOLIC_SAT_EN
        logic [BITS_C-1:0] s;
        s = x + y;
        if ((x[BITS_C-1] == y[BITS_C-1]) && (s[BITS_C-1] != x[BITS_C-1]))
            s = x[BITS_C-1] ? {1'b1, {(BITS_C-1){1'b0}}} : {1'b0, {(BITS_C-1){1'b1}}};
        return s;
`else
        return x + y;
`endif
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and array control
    always_comb begin
        state_next = state;
        clear      = 1'b0;
        step       = 1'b0;
        last_row   = (out_row_idx == RW'(DIM_R - 1));
        case (state)
            IDLE: begin
                if (start) begin
                    clear      = 1'b1;
                    state_next = (k_len == '0) ? DRAIN : LOAD;
                end
            end
            LOAD: begin
                step = in_valid;
                if (in_valid && (k_rem == KW'(1))) state_next = FLUSH;
            end
            FLUSH: begin
                step = 1'b1;
                if (flush_cnt == FW'(FLUSH_LEN - 1)) state_next = DRAIN;
            end
            DRAIN: begin
                if (out_ready && last_row) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Remaining beats and flush length counters
    always_ff @(posedge clk) begin
        if (rst) begin
            k_rem     <= '0;
            flush_cnt <= '0;
        end else begin
            if (clear)                          k_rem <= k_len;
            else if (state == LOAD && in_valid) k_rem <= k_rem - KW'(1);
            if (state == FLUSH) flush_cnt <= flush_cnt + FW'(1);
            else                flush_cnt <= '0;
        end
    end

    // Operand injection: live data in LOAD, zeros while flushing
    always_comb begin
        for (int i = 0; i < int'(DIM_R); i++) inj_a[i] = (state == LOAD) ? a_col[i] : '0;
        for (int j = 0; j < int'(DIM_C); j++) inj_b[j] = (state == LOAD) ? b_row[j] : '0;
    end

    // A skew: row i delayed by i steps
    for (genvar gi = 0; gi < int'(DIM_R); gi++) begin : g_skew_a
        if (gi == 0) begin : g_direct
            assign a_edge[gi] = inj_a[gi];
        end else begin : g_chain
            logic signed [BITS_AB-1:0] sr [gi];
            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    for (int d = 0; d < gi; d++) sr[d] <= '0;
                end else if (step) begin
                    sr[0] <= inj_a[gi];
                    for (int d = 1; d < gi; d++) sr[d] <= sr[d-1];
                end
            end
            assign a_edge[gi] = sr[gi-1];
        end
    end

    // B skew: column j delayed by j steps
    for (genvar gj = 0; gj < int'(DIM_C); gj++) begin : g_skew_b
        if (gj == 0) begin : g_direct
            assign b_edge[gj] = inj_b[gj];
        end else begin : g_chain
            logic signed [BITS_AB-1:0] sr [gj];
            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    for (int d = 0; d < gj; d++) sr[d] <= '0;
                end else if (step) begin
                    sr[0] <= inj_b[gj];
                    for (int d = 1; d < gj; d++) sr[d] <= sr[d-1];
                end
            end
            assign b_edge[gj] = sr[gj-1];
        end
    end

    // PE operand routing: A flows right, B flows down
    for (genvar gi = 0; gi < int'(DIM_R); gi++) begin : g_row
        for (genvar gj = 0; gj < int'(DIM_C); gj++) begin : g_col
            logic signed [PW-1:0] full;
            if (gj == 0) begin : g_a_edge
                assign a_in[gi][gj] = a_edge[gi];
            end else begin : g_a_pass
                assign a_in[gi][gj] = a_pe[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign b_in[gi][gj] = b_edge[gj];
            end else begin : g_b_pass
                assign b_in[gi][gj] = b_pe[gi-1][gj];
            end
            assign full         = a_in[gi][gj] * b_in[gi][gj];
            assign prod[gi][gj] = BITS_C'(full);
        end
    end

    // PE pipeline registers and accumulators; the grid only moves on a step
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < int'(DIM_R); i++)
                for (int j = 0; j < int'(DIM_C); j++) begin
                    a_pe[i][j] <= '0;
                    b_pe[i][j] <= '0;
                    acc[i][j]  <= '0;
                end
        end else if (step) begin
            for (int i = 0; i < int'(DIM_R); i++)
                for (int j = 0; j < int'(DIM_C); j++) begin
                    a_pe[i][j] <= a_in[i][j];
                    b_pe[i][j] <= b_in[i][j];
                    acc[i][j]  <= acc_add(acc[i][j], prod[i][j]);
                end
        end
    end

    // Registered outputs. The last flush step only adds zeros, so acc is
    // already final when row 0 is captured on entry to DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            done        <= 1'b0;
            out_row_idx <= '0;
            c_row       <= '0;
        end else begin
            busy      <= (state_next != IDLE);
            in_ready  <= (state_next == LOAD);
            out_valid <= (state_next == DRAIN);
            done      <= (state == DRAIN) && out_ready && last_row;
            if ((state != DRAIN) && (state_next == DRAIN)) begin
                out_row_idx <= '0;
                c_row       <= clear ? '0 : acc[0];
            end else if ((state == DRAIN) && out_ready) begin
                if (last_row) begin
                    out_row_idx <= '0;
                    c_row       <= '0;
                end else begin
                    out_row_idx <= out_row_idx + RW'(1);
                    c_row       <= acc[out_row_idx + RW'(1)];
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// tb_systolic_mm_engine: directed table-driven bench for systolic_mm_engine
// (4x4, 8-bit operands, 16-bit results), plus hand sequences for
// backpressure, ignored start, and reset in the middle of a job.
// Expected results follow SYSTOLIC_SAT_EN when it is defined.
module tb_systolic_mm_engine;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [7:0]            k_len;
    logic                  busy;
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0][7:0]       a_col;
    logic [3:0][7:0]       b_row;
    logic                  out_valid;
    logic                  out_ready;
    logic [1:0]            out_row_idx;
    logic [3:0][15:0]      c_row;
    logic                  done;

    always #5 clk = ~clk;

    systolic_mm_engine #(
        .BITS_AB(8), .BITS_C(16), .DIM_R(4), .DIM_C(4), .KW(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_row_idx(out_row_idx),
        .c_row(c_row), .done(done)
    );

    typedef struct {
        int                     k;
        int                     gap;
        logic [3:0][3:0][7:0]   a;
        logic [3:0][3:0][7:0]   b;
        logic [3:0][3:0][15:0]  c;
    } vec_t;

    vec_t tv [6];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [3:0][7:0] r8(input int e0, input int e1, input int e2, input int e3);
        logic [3:0][7:0] r;
        r[0] = 8'(e0); r[1] = 8'(e1); r[2] = 8'(e2); r[3] = 8'(e3);
        return r;
    endfunction

    function automatic logic [3:0][15:0] r16(input int e0, input int e1, input int e2, input int e3);
        logic [3:0][15:0] r;
        r[0] = 16'(e0); r[1] = 16'(e1); r[2] = 16'(e2); r[3] = 16'(e3);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one job: offers beat 0 together with start (must be ignored), feeds
    // K beats with optional bubbles, then drains four rows.
    task automatic run_job(input vec_t v, input bit ign, input int stall);
        int n;
        start     = 1'b1;
        k_len     = 8'(v.k);
        in_valid  = 1'b1;
        a_col     = v.a[0];
        b_row     = v.b[0];
        out_ready = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(1));
        if (v.k == 0) chk("k0_drain_next", 64'(out_valid), 64'(1));
        else          chk("ready_in_load", 64'(in_ready), 64'(1));

        for (int kk = 0; kk < v.k; kk++) begin
            n = 0;
            while (!in_ready && n < 50) begin tick(); n++; end
            chk("in_ready_wait", 64'(in_ready), 64'(1));
            in_valid = 1'b1;
            a_col    = v.a[kk];
            b_row    = v.b[kk];
            tick();
            in_valid = 1'b0;
            if (kk < v.k - 1) begin
                for (int g = 0; g < v.gap; g++) begin
                    chk("bubble_ready", 64'(in_ready), 64'(1));
                    tick();
                end
            end
        end

        if (ign) begin
            start = 1'b1;
            k_len = 8'd2;
            tick();
            start = 1'b0;
            chk("flush_start_busy", 64'(busy), 64'(1));
            chk("flush_start_ready", 64'(in_ready), 64'(0));
        end

        n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        chk("out_valid_wait", 64'(out_valid), 64'(1));

        for (int r = 0; r < 4; r++) begin
            if (r == stall) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk("stall_valid", 64'(out_valid), 64'(1));
                    chk("stall_idx", 64'(out_row_idx), 64'(r));
                    chk("stall_c", 64'(c_row), 64'(v.c[r]));
                end
                out_ready = 1'b1;
            end
            chk("row_valid", 64'(out_valid), 64'(1));
            chk("row_idx", 64'(out_row_idx), 64'(r));
            chk("row_c", 64'(c_row), 64'(v.c[r]));
            chk("row_no_done", 64'(done), 64'(0));
            if (ign && r == 1) start = 1'b1;
            tick();
            start = 1'b0;
        end

        chk("done_pulse", 64'(done), 64'(1));
        chk("done_busy", 64'(busy), 64'(0));
        chk("done_valid", 64'(out_valid), 64'(0));
        chk("done_idx", 64'(out_row_idx), 64'(0));
        chk("done_c", 64'(c_row), 64'(0));
        tick();
        chk("done_once", 64'(done), 64'(0));
        chk("idle_busy", 64'(busy), 64'(0));
        if (ign) begin
            for (int s = 0; s < 3; s++) begin
                tick();
                chk("ign_no_done", 64'(done), 64'(0));
                chk("ign_idle", 64'(busy), 64'(0));
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        k_len     = '0;
        in_valid  = 1'b0;
        a_col     = '0;
        b_row     = '0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_idx", 64'(out_row_idx), 64'(0));
        chk("rst_c", 64'(c_row), 64'(0));
        rst = 1'b0;
        tick();

        // 0: identity A, 1: same with bubbles
        tv[0].k = 4; tv[0].gap = 0;
        for (int k = 0; k < 4; k++) tv[0].a[k] = r8(k == 0, k == 1, k == 2, k == 3);
        tv[0].b[0] = r8(1, 2, 3, 4);    tv[0].b[1] = r8(5, 6, 7, 8);
        tv[0].b[2] = r8(-1, -2, -3, -4); tv[0].b[3] = r8(0, 9, 0, 9);
        tv[0].c[0] = r16(1, 2, 3, 4);   tv[0].c[1] = r16(5, 6, 7, 8);
        tv[0].c[2] = r16(-1, -2, -3, -4); tv[0].c[3] = r16(0, 9, 0, 9);
        tv[1] = tv[0];
        tv[1].gap = 3;
        // 2: general K=2 product
        tv[2].k = 2; tv[2].gap = 1;
        tv[2].a[0] = r8(1, 2, 3, 4);  tv[2].a[1] = r8(-1, 0, 2, 1);
        tv[2].a[2] = '0;              tv[2].a[3] = '0;
        tv[2].b[0] = r8(1, 1, 2, -3); tv[2].b[1] = r8(5, -2, 0, 1);
        tv[2].b[2] = '0;              tv[2].b[3] = '0;
        tv[2].c[0] = r16(-4, 3, 2, -4);
        tv[2].c[1] = r16(2, 2, 4, -6);
        tv[2].c[2] = r16(13, -1, 6, -7);
        tv[2].c[3] = r16(9, 2, 8, -11);
        // 3: 127*127 x4, 4: -128*127 x4
        tv[3].k = 4; tv[3].gap = 0;
        tv[4].k = 4; tv[4].gap = 0;
        for (int k = 0; k < 4; k++) begin
            tv[3].a[k] = r8(127, 127, 127, 127);
            tv[3].b[k] = r8(127, 127, 127, 127);
            tv[4].a[k] = r8(-128, -128, -128, -128);
            tv[4].b[k] = r8(127, 127, 127, 127);
`ifdef SYSTOLIC_SAT_EN
            tv[3].c[k] = r16(32767, 32767, 32767, 32767);
            tv[4].c[k] = r16(-32768, -32768, -32768, -32768);
`else
            tv[3].c[k] = r16(-1020, -1020, -1020, -1020);
            tv[4].c[k] = r16(512, 512, 512, 512);
`endif
        end
        // 5: empty reduction
        tv[5].k = 0; tv[5].gap = 0;
        tv[5].a = '0; tv[5].b = '0; tv[5].c = '0;

        for (int i = 0; i < 6; i++) run_job(tv[i], 1'b0, -1);

        // Backpressure on row 2
        run_job(tv[0], 1'b0, 2);
        // Start pulses during FLUSH and DRAIN
        run_job(tv[0], 1'b1, -1);

        // Reset in the middle of LOAD, then a fresh job
        start = 1'b1;
        k_len = 8'd4;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            a_col    = tv[0].a[k];
            b_row    = tv[0].b[k];
            tick();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_ready", 64'(in_ready), 64'(0));
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        chk("mid_rst_c", 64'(c_row), 64'(0));
        tick();
        run_job(tv[0], 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
